// File: rtl/dffram_arbiter_2p_pkg.sv
// Shared types and sizes for the two-port DFFRAM128x32 arbiter.
// Byte-lane count is derived from the data width.
package dffram_arb_pkg;

    typedef logic port_id_t;

    localparam int A_WIDTH = 7;
    localparam int D_WIDTH = 32;
    localparam int NB      = D_WIDTH / 8;

    localparam logic [NB-1:0] WE_NONE = 4'b0000;
    localparam logic [NB-1:0] WE_ALL  = 4'b1111;

endpackage

// File: rtl/dffram_arbiter_2p_if.sv
// One requester port of the arbiter: valid/ready request channel plus read-return channel.
// master = bus-side requester, slave = arbiter.
interface dffram_arbiter_2p_if;

    logic                              valid;
    logic                              ready;
    logic [dffram_arb_pkg::NB-1:0]      we;
    logic [dffram_arb_pkg::A_WIDTH-1:0] addr;
    logic [dffram_arb_pkg::D_WIDTH-1:0] wdata;
    logic                              rvalid;
    logic [dffram_arb_pkg::D_WIDTH-1:0] rdata;

    modport master (output valid, we, addr, wdata, input ready, rvalid, rdata);
    modport slave  (input valid, we, addr, wdata, output ready, rvalid, rdata);

endinterface

// File: rtl/dffram_arbiter_2p_rr_arb2.sv
// rr_arb2: two-requester grant, one-hot or zero. Round-robin on contention, or port 0 always
// wins when DFFRAM_ARB_FIXED_PRI_EN is defined. Purely combinational, no backpressure of its own.
module rr_arb2
    import dffram_arb_pkg::*;
(
    input  logic [1:0] req,
    input  port_id_t   last_grant,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01: gnt = 2'b01;
            2'b10: gnt = 2'b10;
            2'b11: begin
`ifdef DFFRAM_ARB_FIXED_PRI_EN
                gnt = 2'b01;
`else
                // contention goes to whichever port did not win the last access
                gnt = (last_grant == 1'b1) ? 2'b01 : 2'b10;
`endif
            end
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/dffram_arbiter_2p.sv
// Purpose: shares one single-port DFFRAM128x32 between two requesters (config: DFFRAM_ARB_FIXED_PRI_EN).
// Latency: grant/RAM drive combinational in the request cycle; read data returns one cycle after accept.
// Backpressure: loser sees ready=0 and must hold its request; 1 access/cycle, no read-return stall.
module dffram_arbiter_2p
    import dffram_arb_pkg::*;
(
    input  logic                CLK,
    input  logic                RST,
    dffram_arbiter_2p_if.slave  p0,
    dffram_arbiter_2p_if.slave  p1,
    output logic                ram_en,
    output logic [NB-1:0]       ram_we,
    output logic [A_WIDTH-1:0]  ram_addr,
    output logic [D_WIDTH-1:0]  ram_di,
    input  logic [D_WIDTH-1:0]  ram_do
);

    port_id_t   last_grant;
    logic       rd_pend;
    port_id_t   rd_port;
    logic [1:0] gnt;
    logic       accept;

    rr_arb2 u_arb (
        .req        ({p1.valid, p0.valid}),
        .last_grant (last_grant),
        .gnt        (gnt)
    );

    assign p0.ready = gnt[0];
    assign p1.ready = gnt[1];
    assign accept   = |gnt;
    assign ram_en   = p0.valid | p1.valid;

    always_comb begin
        ram_we   = WE_NONE;
        ram_addr = '0;
        ram_di   = '0;
        if (gnt[0]) begin
            ram_we   = p0.we;
            ram_addr = p0.addr;
            ram_di   = p0.wdata;
        end else if (gnt[1]) begin
            ram_we   = p1.we;
            ram_addr = p1.addr;
            ram_di   = p1.wdata;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            last_grant <= 1'b1;
            rd_pend    <= 1'b0;
            rd_port    <= 1'b0;
        end else begin
            rd_pend <= accept && (ram_we == WE_NONE);
            if (accept) begin
                last_grant <= gnt[1];
                rd_port    <= gnt[1];
            end
        end
    end

    // Do0 is only meaningful on the cycle after an accepted read
    assign p0.rvalid = rd_pend && (rd_port == 1'b0);
    assign p1.rvalid = rd_pend && (rd_port == 1'b1);
    assign p0.rdata  = p0.rvalid ? ram_do : '0;
    assign p1.rdata  = p1.rvalid ? ram_do : '0;

endmodule

// File: tb/tb_dffram_arbiter_2p.sv
// Bench for dffram_arbiter_2p: behavioural DFFRAM model, reference memory and read-return scoreboard.
// Expectations follow round-robin, or fixed priority when DFFRAM_ARB_FIXED_PRI_EN is defined.
module tb_dffram_arbiter_2p;
    import dffram_arb_pkg::*;

    logic               CLK = 1'b0;
    logic               RST = 1'b1;
    logic               ram_en;
    logic [NB-1:0]      ram_we;
    logic [A_WIDTH-1:0] ram_addr;
    logic [D_WIDTH-1:0] ram_di;
    logic [D_WIDTH-1:0] ram_do;

    dffram_arbiter_2p_if p0_if ();
    dffram_arbiter_2p_if p1_if ();

    dffram_arbiter_2p dut (
        .CLK      (CLK),
        .RST      (RST),
        .p0       (p0_if),
        .p1       (p1_if),
        .ram_en   (ram_en),
        .ram_we   (ram_we),
        .ram_addr (ram_addr),
        .ram_di   (ram_di),
        .ram_do   (ram_do)
    );

    always #5 CLK = ~CLK;

    // Behavioural macro: registered Do0, zero when not enabled
    logic [D_WIDTH-1:0] ram_mem [128];
    always @(posedge CLK) begin
        if (ram_en) begin
            ram_do <= ram_mem[ram_addr];
            for (int b = 0; b < NB; b++)
                if (ram_we[b]) ram_mem[ram_addr][b*8 +: 8] <= ram_di[b*8 +: 8];
        end else begin
            ram_do <= '0;
        end
    end

    typedef struct {
        logic               port;
        logic [D_WIDTH-1:0] data;
    } rd_t;

    rd_t                exp_q [$];
    logic [D_WIDTH-1:0] mem_m [128];
    logic               tb_last;
    int                 vectors = 0;
    int                 errors  = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void model_write(input logic [A_WIDTH-1:0] a, input logic [NB-1:0] we,
                                        input logic [D_WIDTH-1:0] d);
        for (int b = 0; b < NB; b++)
            if (we[b]) mem_m[a][b*8 +: 8] = d[b*8 +: 8];
    endfunction

    // Read-return scoreboard
    always @(negedge CLK) begin
        if (p0_if.rvalid === 1'b1 || p1_if.rvalid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check_val("rv_unexpected", {p1_if.rvalid, p0_if.rvalid}, 0);
            end else begin
                rd_t e;
                e = exp_q.pop_front();
                check_val("rv_port", {p1_if.rvalid, p0_if.rvalid}, e.port ? 2'b10 : 2'b01);
                check_val("rdata", e.port ? p1_if.rdata : p0_if.rdata, e.data);
                check_val("rdata_idle", e.port ? p0_if.rdata : p1_if.rdata, 0);
            end
        end
    end

    // Single-port access held for one cycle; ready must be immediate
    task automatic access(input logic port, input logic [NB-1:0] we,
                          input logic [A_WIDTH-1:0] a, input logic [D_WIDTH-1:0] d);
        if (port) begin
            p1_if.valid = 1'b1; p1_if.we = we; p1_if.addr = a; p1_if.wdata = d;
        end else begin
            p0_if.valid = 1'b1; p0_if.we = we; p0_if.addr = a; p0_if.wdata = d;
        end
        @(negedge CLK);
        check_val(port ? "acc_rdy1" : "acc_rdy0", port ? p1_if.ready : p0_if.ready, 1);
        if (we == WE_NONE) exp_q.push_back('{port: port, data: mem_m[a]});
        else model_write(a, we, d);
        tb_last = port;
        @(posedge CLK); #1;
        p0_if.valid = 1'b0;
        p1_if.valid = 1'b0;
    endtask

    // Both ports stream reads; grants follow the bench's own arbitration model
    task automatic run_pair(input int n0, input int b0, input int s0,
                            input int n1, input int b1, input int s1,
                            input int exp_cycles, input string tag);
        int  i0 = 0;
        int  i1 = 0;
        int  cyc = 0;
        logic eg;
        while ((i0 < n0 || i1 < n1) && cyc < 100) begin
            p0_if.valid = (i0 < n0); p0_if.we = WE_NONE; p0_if.addr = A_WIDTH'(b0 + i0 * s0);
            p1_if.valid = (i1 < n1); p1_if.we = WE_NONE; p1_if.addr = A_WIDTH'(b1 + i1 * s1);
            @(negedge CLK);
            if (p0_if.valid && p1_if.valid) begin
`ifdef DFFRAM_ARB_FIXED_PRI_EN
                eg = 1'b0;
`else
                eg = ~tb_last;
`endif
            end else begin
                eg = p1_if.valid;
            end
            check_val({tag, "_rdy"}, {p1_if.ready, p0_if.ready}, eg ? 2'b10 : 2'b01);
            if (eg) begin
                exp_q.push_back('{port: 1'b1, data: mem_m[p1_if.addr]});
                i1++;
            end else begin
                exp_q.push_back('{port: 1'b0, data: mem_m[p0_if.addr]});
                i0++;
            end
            tb_last = eg;
            @(posedge CLK); #1;
            cyc++;
        end
        p0_if.valid = 1'b0;
        p1_if.valid = 1'b0;
        check_val({tag, "_cycles"}, cyc, exp_cycles);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 128; i++) begin
            mem_m[i]   = '0;
            ram_mem[i] = '0;
        end
        tb_last = 1'b1;
        p0_if.valid = 1'b0; p0_if.we = WE_NONE; p0_if.addr = '0; p0_if.wdata = '0;
        p1_if.valid = 1'b0; p1_if.we = WE_NONE; p1_if.addr = '0; p1_if.wdata = '0;
        RST = 1'b1;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check_val("rst_rvalid", {p1_if.rvalid, p0_if.rvalid}, 0);
        check_val("rst_ready", {p1_if.ready, p0_if.ready}, 0);
        check_val("idle_ram_en", ram_en, 0);
        check_val("idle_ram_we", ram_we, 0);
        check_val("idle_ram_addr", ram_addr, 0);
        check_val("idle_ram_di", ram_di, 0);
        @(posedge CLK); #1;
        RST = 1'b0;

        // write then read-after-write on p0
        access(1'b0, WE_ALL, 7'd5, 32'hDEADBEEF);
        access(1'b0, WE_NONE, 7'd5, '0);

        // partial-lane write at the top address on p1
        access(1'b1, WE_ALL, 7'd127, 32'h11223344);
        access(1'b1, 4'b0010, 7'd127, 32'h0000AB00);
        access(1'b1, WE_NONE, 7'd127, '0);
        check_val("lane_model", mem_m[127], 32'h1122AB44);
        repeat (2) @(posedge CLK); #1;

        // sustained contention alternates
        run_pair(2, 5, 0, 2, 127, 0, 4, "alt");

        // preload 0..15 then interleaved streaming reads
        for (int i = 0; i < 16; i++)
            access(i[3], WE_ALL, A_WIDTH'(i), $urandom);
        run_pair(8, 0, 1, 8, 8, 1, 16, "stream");
        repeat (2) @(posedge CLK); #1;

        // reset coincident with an accepted p0 read
        p0_if.valid = 1'b1; p0_if.we = WE_NONE; p0_if.addr = 7'd3;
        RST = 1'b1;
        @(negedge CLK);
        check_val("rst_acc_rdy", p0_if.ready, 1);
        @(posedge CLK); #1;
        RST = 1'b0;
        p0_if.valid = 1'b0;
        tb_last = 1'b1;
        @(negedge CLK);
        check_val("rst_no_rvalid", p0_if.rvalid, 0);
        @(posedge CLK); #1;
        run_pair(1, 3, 0, 1, 9, 0, 2, "rst_cont");

        // three-deep p0 burst against a single p1 request
        run_pair(3, 40, 1, 1, 50, 1, 4, "pri");

        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check_val("q_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
